// File: rtl/y_tile_pack_writer.sv
`default_nettype none
// ============================================================================
// Module   : y_tile_pack_writer
// Purpose  : Packs 4-lane y_t tiles into wide result-SRAM words, writes them
//            at a wrapping auto-incrementing address, tags vector ends and
//            counts completed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module y_tile_pack_writer #(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DATA_W     = 256,
  parameter int D          = 256,
  parameter int OUT_ADDR_W = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_axis_TVALID,
  output logic                            s_axis_TREADY,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0] s_axis_TDATA,
  input  logic                            flush,
  output logic                            m_wr_en,
  input  logic                            m_wr_ready,
  output logic [OUT_ADDR_W-1:0]           m_wr_addr,
  output logic [DATA_W-1:0]               m_wr_data,
  output logic                            m_wr_last,
  output logic                            vec_done,
  output logic [15:0]                     vec_cnt
);

  localparam int LANES     = DATA_W / DATA_WIDTH;
  localparam int TPW       = LANES / TILE_SIZE;
  localparam int WPV       = D / LANES;
  localparam int TILE_BITS = TILE_SIZE * DATA_WIDTH;
  localparam int TIDX_W    = $clog2(TPW);
  localparam int WIDX_W    = $clog2(WPV);

  localparam logic [TIDX_W-1:0] TIDX_LAST = TIDX_W'(TPW - 1);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WPV - 1);

  logic [DATA_W-1:0]     pack_q, pack_d;
  logic [TIDX_W-1:0]     tile_idx_q, tile_idx_d;
  logic [WIDX_W-1:0]     word_idx_q, word_idx_d;
  logic [OUT_ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  wr_en_q, wr_en_d;
  logic [OUT_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic                  wr_last_q, wr_last_d;
  logic                  vec_done_q, vec_done_d;
  logic [15:0]           vec_cnt_q, vec_cnt_d;

  logic                  w_can_take;
  logic                  w_fire;
  logic                  w_tready;
  logic                  w_accept;
  logic                  w_flush_req;
  logic                  w_has_data;
  logic                  w_full_launch;
  logic                  w_flush_launch;
  logic                  w_launch;
  logic                  w_launch_last;
  logic [DATA_W-1:0]     w_pack_ins;

  // Handshake, packing and launch decisions plus all next-state values.
  always_comb begin
    // The output register can take a new word when empty or draining now.
    w_can_take  = !wr_en_q || m_wr_ready;
    w_fire      = wr_en_q && m_wr_ready;
    // Only the word-completing tile has to wait for room in the output.
    w_tready    = !((tile_idx_q == TIDX_LAST) && !w_can_take);
    w_accept    = s_axis_TVALID && w_tready;
    w_flush_req = flush || flush_pend_q;
    w_has_data  = w_accept || (tile_idx_q != '0);

    w_pack_ins = pack_q;
    for (int k = 0; k < TPW; k++) begin
      if (w_accept && (tile_idx_q == TIDX_W'(k))) begin
        w_pack_ins[k*TILE_BITS +: TILE_BITS] = s_axis_TDATA;
      end
    end

    // A tile completing the word wins over flush: the word is simply full.
    w_full_launch  = w_accept && (tile_idx_q == TIDX_LAST);
    w_flush_launch = w_flush_req && w_has_data && w_can_take && !w_full_launch;
    w_launch       = w_full_launch || w_flush_launch;
    w_launch_last  = (word_idx_q == WIDX_LAST) || w_flush_launch;

    // A flush that finds data but no room waits; an empty flush is dropped.
    flush_pend_d = w_flush_req && w_has_data && !w_can_take;

    pack_d     = w_pack_ins;
    tile_idx_d = tile_idx_q;
    if (w_launch) begin
      pack_d     = '0;
      tile_idx_d = '0;
    end else if (w_accept) begin
      tile_idx_d = tile_idx_q + 1'b1;
    end

    word_idx_d = word_idx_q;
    if (w_launch) begin
      word_idx_d = w_launch_last ? '0 : word_idx_q + 1'b1;
    end

    addr_cnt_d = w_fire ? addr_cnt_q + 1'b1 : addr_cnt_q;

    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_last_d = wr_last_q;
    if (w_launch) begin
      wr_en_d   = 1'b1;
      // When refilling in the cycle of a write, the new word takes the next address.
      wr_addr_d = addr_cnt_d;
      wr_data_d = w_pack_ins;
      wr_last_d = w_launch_last;
    end else if (w_fire) begin
      wr_en_d = 1'b0;
    end

    vec_done_d = w_fire && wr_last_q;
    vec_cnt_d  = vec_cnt_q + {15'd0, vec_done_d};
  end

  // State register with synchronous reset; reset discards partial and held words.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q       <= '0;
      tile_idx_q   <= '0;
      word_idx_q   <= '0;
      addr_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_last_q    <= 1'b0;
      vec_done_q   <= 1'b0;
      vec_cnt_q    <= '0;
    end else begin
      pack_q       <= pack_d;
      tile_idx_q   <= tile_idx_d;
      word_idx_q   <= word_idx_d;
      addr_cnt_q   <= addr_cnt_d;
      flush_pend_q <= flush_pend_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_last_q    <= wr_last_d;
      vec_done_q   <= vec_done_d;
      vec_cnt_q    <= vec_cnt_d;
    end
  end

  assign s_axis_TREADY = w_tready;
  assign m_wr_en       = wr_en_q;
  assign m_wr_addr     = wr_addr_q;
  assign m_wr_data     = wr_data_q;
  assign m_wr_last     = wr_last_q;
  assign vec_done      = vec_done_q;
  assign vec_cnt       = vec_cnt_q;

endmodule
`default_nettype wire

// File: doc/y_tile_pack_writer.md
# y_tile_pack_writer

Result-buffer writer at the tail of the recurrence/gate pipeline. Accepts the 4-lane y_t tile stream from the gate stage over a valid/ready handshake and packs consecutive tiles into DATA_W-bit words. Writes those words to the result SRAM write port at an auto-incrementing, wrapping address. It is the writer counterpart of the controller's packed-word x_t reader. It tags the last word of every D-element vector and reports vector completion.

## Interface
- TILE_SIZE, 4, lanes per input tile
- DATA_WIDTH, 16, bits per lane (signed Q-format, passed through unchanged)
- DATA_W, 256, SRAM word width; LANES = DATA_W/DATA_WIDTH = 16, TPW = LANES/TILE_SIZE = 4 tiles per word
- D, 256, elements per vector; WPV = D/LANES = 16 words per vector (D must be a multiple of LANES)
- OUT_ADDR_W, 6, SRAM address width; buffer depth 2^OUT_ADDR_W words
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_axis_TVALID  in  1  tile valid
- s_axis_TREADY  out  1  tile accepted when VALID&&READY
- s_axis_TDATA  in  TILE_SIZE x DATA_WIDTH  signed tile lanes
- flush  in  1  single-cycle request: emit partial word zero-padded, end current vector
- m_wr_en  out  1  write word valid (held until m_wr_ready)
- m_wr_ready  in  1  SRAM port accepts write this cycle
- m_wr_addr  out  OUT_ADDR_W  word address
- m_wr_data  out  DATA_W  packed word
- m_wr_last  out  1  word is last of vector
- vec_done  out  1  one-cycle pulse after last word of a vector written
- vec_cnt  out  16  completed vectors, wraps at 2^16

## Operation
- Pack register plus tile_idx (0..TPW-1). Tile accepted at tile_idx k, lane i goes to bits [(k*TILE_SIZE+i)*DATA_WIDTH +: DATA_WIDTH]; tile_idx++.
- Word launch: on acceptance of tile TPW-1, or on flush with tile_idx>0 (unfilled lanes forced 0). Packed word moves to output register; m_wr_en=1; tile_idx->0; pack register cleared.
- Output register is one-deep; write fires on m_wr_en&&m_wr_ready. A launch in the same cycle as a fire refills it with no bubble.
- s_axis_TREADY = !(m_wr_en && !m_wr_ready && tile_idx==TPW-1). It is combinational on m_wr_ready. Tiles 0..TPW-2 are always accepted.
- Addressing: addr_cnt increments on each fire; OUT_ADDR_W-bit wrap (2^OUT_ADDR_W-1 -> 0). m_wr_addr = addr_cnt of the held word, captured at launch.
- Vector tracking: word_idx (0..WPV-1) increments at launch. m_wr_last=1 when word_idx==WPV-1 or the launch was flush-caused. word_idx resets to 0 after a last word.
- A flush with tile_idx==0 and no launch is ignored; word_idx is unchanged.
- Flush in the same cycle as an accepted tile: the tile is packed first, then the word launches padded. If that tile was TPW-1, launch is normal (no padding).
- Flush while launch is blocked (output full, not draining) is held pending. It is applied in the first cycle the output register can take a word.
- vec_done pulses the cycle after a fire with m_wr_last=1; vec_cnt increments in that same cycle.
- No arithmetic on data; lanes are stored bit-exact.

## Timing
- Reset (rst=1 at clock edge): m_wr_en=0, m_wr_addr=0, m_wr_data=0, m_wr_last=0, vec_done=0, vec_cnt=0. Also tile_idx=0, word_idx=0, addr_cnt=0, pending flush cleared. s_axis_TREADY=1 from the first cycle after reset.
- Reset mid-word or mid-vector discards the partial pack and any held, unwritten word. No write is issued for them.
- Latency: tile TPW-1 accepted at edge t -> m_wr_en=1 with its word from t+1.
- Throughput: 1 tile/cycle sustained, 1 word per TPW cycles, with m_wr_ready=1.
- Backpressure: m_wr_en, m_wr_addr, m_wr_data, m_wr_last stable while m_wr_en && !m_wr_ready.
- Input data is sampled only on VALID&&READY. TVALID may drop between tiles without affecting state.

## Test plan
- Lane j of tile n = n*4+j (n=0..63), m_wr_ready=1 -> 16 writes to addresses 0..15. Word w lane l = 16w+l. m_wr_last only on address 15. vec_done pulses once, one cycle after that write; vec_cnt=1.
- Same stream with m_wr_ready low for 5 cycles at word 2 -> word 2 held stable for 5 cycles. TREADY drops only while tile 3 of word 3 is presented. Data and addresses identical to the first test.
- Stream 70 vectors continuously -> addresses wrap 63->0 after 64 words, no gap. vec_cnt=70.
- 6 tiles then flush -> word 0 full, then word 1 at address 1 with lanes 8..15 = 0 and m_wr_last=1. vec_done pulses; the next tile is packed at lane 0 of word_idx 0.
- Flush with tile_idx==0 -> no write, no vec_done. Flush in the same cycle as tile 1 accepted -> word with lanes 0..7 valid, 8..15 zero.
- rst asserted after 2 tiles and a held word -> all outputs 0 the next cycle, no write issued. The next 4 tiles produce a word at address 0.
